music_fx_engine: RTL and testbench
==================================

Name: music_fx_engine

Overview:
- Parametrised successor to the fixed-function music-feature block. Takes one square-wave tone from the tone generator and produces an octave-shifted audio output, a tremolo-gated output, and a Johnson-counter LED chase.
- Adds selectable octave modes (-2, -1, bypass, +1), a programmable tremolo rate, and a parametrised LED chain length.
- Sits between the tone generator and the top-level output pins, in the single system clock domain.

Parameters:
- CNT_W, 16: width of the half-period measurement counter used for octave-up.
- LED_N, 6: Johnson counter length; chase period is 2*LED_N steps.
- LFO_W, 20: width of the free-running tremolo LFO counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  block enable.
- tone_in  in  1  square-wave tone; may be asynchronous to clk.
- octave_sel  in  2  00 bypass, 01 down one octave, 10 down two octaves, 11 up one octave.
- tremolo_ena  in  1  enables tremolo gating on trem_out.
- trem_rate  in  4  LFO tap select; higher value gives faster tremolo.
- led_ena  in  1  enables led_out.
- audio_out  out  1  octave-processed tone.
- trem_out  out  1  audio_out gated by the LFO.
- led_out  out  LED_N  Johnson LED pattern.
- up_valid  out  1  octave-up period measurement is valid.

Behaviour:
- Reset: every flop is cleared to 0, so audio_out, trem_out, led_out and up_valid are all 0.
- Input synchroniser: s1 <- tone_in, then s2 <- s1, then s3 <- s2. It always runs, even when ena=0.
- Edge detection: edge = s2 ^ s3; rise = s2 & ~s3.
- Octave-down:
  - 2-bit div counter increments on rise.
  - down1 = div[0]; down2 = div[1].
- Half-period measurement:
  - hp_cnt increments every cycle and saturates at all-ones.
  - On an edge cycle: hp_len <= hp_cnt+1 (saturating) and hp_cnt <= 0.
- up_valid:
  - Set on the second edge after reset or after any invalidation.
  - Cleared when hp_cnt reaches all-ones, i.e. the tone has stopped.
  - While cleared, the edge counter restarts.
- Octave-up register up_q:
  - Toggles on every edge cycle.
  - Also toggles when up_valid, (hp_len>>1) != 0, and hp_cnt+1 == hp_len>>1.
  - If an edge and a mid-point toggle fall in the same cycle, up_q toggles once only.
  - While up_valid=0, up_q follows s2.
- audio_out (registered), selected by octave_sel:
  - 00: s2
  - 01: down1
  - 10: down2
  - 11: up_q
- Latency and mode changes:
  - Bypass latency: a tone_in change sampled at clk edge k appears on audio_out after edge k+2.
  - A change of octave_sel takes effect on the next clk edge. No glitch filtering is applied.
- LFO:
  - lfo_cnt free-runs by +1 and wraps modulo 2^LFO_W.
  - gate = lfo_cnt[LFO_W-1-trem_rate]; if trem_rate > LFO_W-1, tap bit 0.
- trem_out (registered) = tremolo_ena ? (audio_sel & gate) : audio_sel, where audio_sel is the same next value that audio_out takes. trem_out therefore aligns with audio_out.
- LED chain:
  - Johnson register j[LED_N-1:0] shifts left with LSB fill ~j[LED_N-1]. It advances on each rising edge of gate.
  - Sequence for LED_N=6: 000000, 000001, 000011, …, 111111, 111110, …, 100000, 000000.
  - j advances regardless of led_ena. led_out = led_ena ? j : 0 (registered).
- ena=0:
  - div, hp_cnt, hp_len, up_q, lfo_cnt and j all hold.
  - audio_out, trem_out and led_out are forced to 0 on the next edge.
  - When ena returns to 1, operation resumes from the held state. up_valid is cleared on resume.
- Reset mid-operation: asserting rst_n low clears all state immediately, with no clock required.

Test Plan:
- Reset, then octave_sel=00 and a tone_in toggle -> audio_out follows after exactly 3 clk edges; trem_out equals audio_out while tremolo_ena=0.
- Tone with 8-clk half-period, octave_sel=01 then 10 -> audio_out half-period is 16 clks, then 32 clks.
- Same 8-clk tone, octave_sel=11 -> up_valid rises after the second edge; audio_out then toggles every 4 clks. Stop the tone -> up_valid falls after 2^CNT_W-1 clks and audio_out holds.
- LFO_W=8 override, tremolo_ena=1, trem_rate=3, steady tone -> trem_out is masked for 16-clk windows every 32 clks; trem_rate=15 clamps to a bit-0 tap.
- led_ena=1, LED_N=6 -> pattern steps 000001 through 100000 to 000000 over 12 gate rises. led_ena=0 -> led_out=0; re-enabling shows the advanced pattern.
- ena low mid-tone, then high -> outputs go 0 and hold; counters resume from their held values, and up_valid re-qualifies only after two new edges. rst_n pulsed low asynchronously mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/music_fx_engine.sv
// music_fx_engine: octave shift (-2/-1/bypass/+1), tremolo gating and Johnson LED chase for one square-wave tone.
// Latency: tone_in to audio_out/trem_out is 3 clk edges (2-flop sync + output register); led_out lags j by one edge.
// Backpressure: none; free-running stream, ena=0 freezes internal state and zeroes the outputs.
module music_fx_engine #(
    parameter int CNT_W = 16,
    parameter int LED_N = 6,
    parameter int LFO_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             tone_in,
    input  logic [1:0]       octave_sel,
    input  logic             tremolo_ena,
    input  logic [3:0]       trem_rate,
    input  logic             led_ena,
    output logic             audio_out,
    output logic             trem_out,
    output logic [LED_N-1:0] led_out,
    output logic             up_valid
);
    logic [2:0]       sync_q, sync_d;
    logic [1:0]       div_q, div_d;
    logic [CNT_W-1:0] hp_cnt_q, hp_cnt_d;
    logic [CNT_W-1:0] hp_len_q, hp_len_d;
    logic             up_valid_q, up_valid_d;
    logic             ecnt_q, ecnt_d;
    logic             up_tog_q, up_tog_d;
    logic             ena_q, ena_d;
    logic             audio_q, audio_d;
    logic             trem_q, trem_d;
    logic [LED_N-1:0] led_q, led_d;
    logic [LFO_W-1:0] lfo_q, lfo_d;
    logic             gate_q, gate_d;
    logic [LED_N-1:0] j_q, j_d;

    logic             s2, s3, tone_edge, tone_rise, hp_sat, resume, valid_eff, mid, gate, audio_sel;
    logic [CNT_W-1:0] half, hp_inc;
    logic [LFO_W-1:0] lfo_sh;
    int unsigned      tap_amt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            div_q      <= '0;
            hp_cnt_q   <= '0;
            hp_len_q   <= '0;
            up_valid_q <= 1'b0;
            ecnt_q     <= 1'b0;
            up_tog_q   <= 1'b0;
            ena_q      <= 1'b0;
            audio_q    <= 1'b0;
            trem_q     <= 1'b0;
            led_q      <= '0;
            lfo_q      <= '0;
            gate_q     <= 1'b0;
            j_q        <= '0;
        end else begin
            sync_q     <= sync_d;
            div_q      <= div_d;
            hp_cnt_q   <= hp_cnt_d;
            hp_len_q   <= hp_len_d;
            up_valid_q <= up_valid_d;
            ecnt_q     <= ecnt_d;
            up_tog_q   <= up_tog_d;
            ena_q      <= ena_d;
            audio_q    <= audio_d;
            trem_q     <= trem_d;
            led_q      <= led_d;
            lfo_q      <= lfo_d;
            gate_q     <= gate_d;
            j_q        <= j_d;
        end
    end

    always_comb begin
        s2        = sync_q[1];
        s3        = sync_q[2];
        tone_edge = s2 ^ s3;
        tone_rise = s2 & ~s3;
        hp_sat    = &hp_cnt_q;
        hp_inc    = hp_sat ? hp_cnt_q : hp_cnt_q + CNT_W'(1);
        // The first cycle back from ena=0 behaves as unqualified: the held period is stale.
        resume    = ena & ~ena_q;
        valid_eff = up_valid_q & ~resume;
        half      = hp_len_q >> 1;
        mid       = valid_eff && (half != '0) && (hp_cnt_q + CNT_W'(1) == half);

        tap_amt   = (32'(trem_rate) > LFO_W - 1) ? 0 : LFO_W - 1 - 32'(trem_rate);
        lfo_sh    = lfo_q >> tap_amt;
        gate      = lfo_sh[0];

        case (octave_sel)
            2'b00:   audio_sel = s2;
            2'b01:   audio_sel = div_q[0];
            2'b10:   audio_sel = div_q[1];
            default: audio_sel = up_tog_q;
        endcase
    end

    always_comb begin
        sync_d     = {sync_q[1:0], tone_in};
        ena_d      = ena;
        div_d      = div_q;
        hp_cnt_d   = hp_cnt_q;
        hp_len_d   = hp_len_q;
        up_valid_d = up_valid_q;
        ecnt_d     = ecnt_q;
        up_tog_d   = up_tog_q;
        lfo_d      = lfo_q;
        gate_d     = gate_q;
        j_d        = j_q;
        audio_d    = 1'b0;
        trem_d     = 1'b0;
        led_d      = '0;
        if (ena) begin
            div_d    = div_q + {1'b0, tone_rise};
            hp_cnt_d = tone_edge ? '0 : hp_inc;
            if (tone_edge) begin
                hp_len_d = hp_inc;
            end
            // A saturated half-period counter means the tone has stopped.
            if (resume || hp_sat) begin
                up_valid_d = 1'b0;
                ecnt_d     = tone_edge;
            end else if (!up_valid_q && tone_edge) begin
                up_valid_d = ecnt_q;
                ecnt_d     = ~ecnt_q;
            end
            up_tog_d = valid_eff ? (up_tog_q ^ (tone_edge | mid)) : s2;
            lfo_d    = lfo_q + LFO_W'(1);
            gate_d   = gate;
            if (gate && !gate_q) begin
                j_d = {j_q[LED_N-2:0], ~j_q[LED_N-1]};
            end
            audio_d = audio_sel;
            trem_d  = tremolo_ena ? (audio_sel & gate) : audio_sel;
            led_d   = led_ena ? j_q : '0;
        end
    end

    assign audio_out = audio_q;
    assign trem_out  = trem_q;
    assign led_out   = led_q;
    assign up_valid  = up_valid_q;
endmodule

// File: tb/tb_music_fx_engine.sv
// Bench for music_fx_engine: randomized and directed stimulus checked against a cycle-level behavioural model.
module tb_music_fx_engine;
    localparam int CW   = 10;
    localparam int LN   = 6;
    localparam int LW   = 8;
    localparam int HMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          ena = 1'b1;
    logic          tone_in = 1'b0;
    logic [1:0]    octave_sel = 2'b00;
    logic          tremolo_ena = 1'b0;
    logic [3:0]    trem_rate = 4'd0;
    logic          led_ena = 1'b0;
    logic          audio_out, trem_out, up_valid;
    logic [LN-1:0] led_out;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int tone_hp = 0;
    int tone_ph = 0;
    int tone_tog = 0;

    // model state
    bit sh1, sh2, sh3;
    int rises, since_edge, hp_len_m, edges_seen, steps, cyc_en;
    bit valid_m, upq_m, gprev, ena_prev, audio_m, trem_m;
    logic [LN-1:0] led_m;

    music_fx_engine #(.CNT_W(CW), .LED_N(LN), .LFO_W(LW)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .tone_in(tone_in), .octave_sel(octave_sel),
        .tremolo_ena(tremolo_ena), .trem_rate(trem_rate), .led_ena(led_ena),
        .audio_out(audio_out), .trem_out(trem_out), .led_out(led_out), .up_valid(up_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [LN-1:0] jpat(int k);
        int m;
        int v;
        m = k % (2 * LN);
        if (m <= LN) v = (1 << m) - 1;
        else v = ((1 << LN) - 1) << (m - LN);
        return v[LN-1:0];
    endfunction

    task automatic model_reset();
        sh1 = 0; sh2 = 0; sh3 = 0;
        rises = 0; since_edge = 0; hp_len_m = 0; edges_seen = 0; steps = 0; cyc_en = 0;
        valid_m = 0; upq_m = 0; gprev = 0; ena_prev = 0; audio_m = 0; trem_m = 0; led_m = '0;
    endtask

    task automatic model_step();
        bit e, r, g, resume, veff, mid, sel_v;
        int tap, half;
        if (!rst_n) begin
            model_reset();
            return;
        end
        e = sh2 != sh3;
        r = sh2 && !sh3;
        tap = (int'(trem_rate) > LW - 1) ? 0 : LW - 1 - int'(trem_rate);
        g = bit'(((cyc_en % (1 << LW)) >> tap) & 1);
        case (octave_sel)
            2'd0: sel_v = sh2;
            2'd1: sel_v = bit'(rises % 2);
            2'd2: sel_v = bit'((rises / 2) % 2);
            default: sel_v = upq_m;
        endcase
        resume = ena && !ena_prev;
        if (ena) begin
            audio_m = sel_v;
            trem_m  = tremolo_ena ? (sel_v & g) : sel_v;
            led_m   = led_ena ? jpat(steps) : '0;
            veff = valid_m && !resume;
            half = hp_len_m / 2;
            mid  = veff && half != 0 && since_edge + 1 == half;
            upq_m = veff ? (upq_m ^ (e | mid)) : sh2;
            if (resume || since_edge == HMAX) begin
                valid_m = 0;
                edges_seen = int'(e);
            end else if (!valid_m && e) begin
                edges_seen++;
                if (edges_seen == 2) begin
                    valid_m = 1;
                    edges_seen = 0;
                end
            end
            if (e) begin
                hp_len_m = (since_edge + 1 > HMAX) ? HMAX : since_edge + 1;
                since_edge = 0;
            end else if (since_edge < HMAX) begin
                since_edge++;
            end
            if (r) rises++;
            if (g && !gprev) steps++;
            gprev = g;
            cyc_en++;
        end else begin
            audio_m = 0;
            trem_m  = 0;
            led_m   = '0;
        end
        ena_prev = ena;
        sh3 = sh2;
        sh2 = sh1;
        sh1 = tone_in;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        if (tone_hp != 0) begin
            tone_ph++;
            if (tone_ph >= tone_hp) begin
                tone_ph = 0;
                tone_in = ~tone_in;
                tone_tog++;
            end
        end
        cyc++;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({audio_out, trem_out, up_valid, led_out} !== '0) begin
            bad++;
            $display("FAIL reset got=%b want=0", {audio_out, trem_out, up_valid, led_out});
        end
        model_reset();
        for (int i = 0; i < 3; i++) step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if ({audio_out, trem_out, up_valid, led_out} !== {audio_m, trem_m, valid_m, led_m}) begin
                bad++;
                $display("FAIL reset_run cyc=%0d got=%b want=%b", cyc, {audio_out, trem_out, up_valid, led_out}, {audio_m, trem_m, valid_m, led_m});
            end
        end
    endtask

    task automatic test_bypass_latency();
        int n;
        octave_sel = 2'b00; tone_hp = 0; tone_in = 1'b0; tremolo_ena = 1'b0;
        for (int i = 0; i < 6; i++) step();
        tone_in = 1'b1;
        n = 0;
        while (n < 10) begin
            step();
            n++;
            total++;
            if ({audio_out, trem_out, up_valid, led_out} !== {audio_m, trem_m, valid_m, led_m}) begin
                bad++;
                $display("FAIL bypass cyc=%0d got=%b want=%b", cyc, {audio_out, trem_out, up_valid, led_out}, {audio_m, trem_m, valid_m, led_m});
            end
            if (audio_out === 1'b1) break;
        end
        total++;
        if (n != 3) begin
            bad++;
            $display("FAIL bypass_latency edges=%0d want=3", n);
        end
        total++;
        if (trem_out !== audio_out) begin
            bad++;
            $display("FAIL bypass_trem got=%b want=%b", trem_out, audio_out);
        end
    endtask

    task automatic run_intervals(input string name, input int cycles, input int want, input bit need_valid);
        int last_t, ntog;
        logic prev;
        last_t = 0; ntog = 0; prev = audio_out;
        for (int i = 0; i < cycles; i++) begin
            step();
            total++;
            if ({audio_out, trem_out, up_valid, led_out} !== {audio_m, trem_m, valid_m, led_m}) begin
                bad++;
                $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, {audio_out, trem_out, up_valid, led_out}, {audio_m, trem_m, valid_m, led_m});
            end
            if (audio_out !== prev && (!need_valid || up_valid === 1'b1)) begin
                if (ntog >= 2) begin
                    total++;
                    if (cyc - last_t != want) begin
                        bad++;
                        $display("FAIL %s_period cyc=%0d got=%0d want=%0d", name, cyc, cyc - last_t, want);
                    end
                end
                ntog++;
                last_t = cyc;
            end
            prev = audio_out;
        end
        total++;
        if (ntog < 4) begin
            bad++;
            $display("FAIL %s_toggles got=%0d want>=4", name, ntog);
        end
    endtask

    task automatic test_octave_down();
        tone_hp = 8; tone_ph = 0;
        octave_sel = 2'b01;
        run_intervals("down1", 160, 16, 1'b0);
        octave_sel = 2'b10;
        run_intervals("down2", 260, 32, 1'b0);
    endtask

    task automatic test_octave_up();
        int n, tog0;
        octave_sel = 2'b11;
        tone_hp = 0;
        for (int i = 0; i < HMAX + 20; i++) step();
        total++;
        if (up_valid !== 1'b0) begin
            bad++;
            $display("FAIL up_idle got=%b want=0", up_valid);
        end
        tone_hp = 8; tone_ph = 0; tog0 = tone_tog;
        n = 0;
        while (up_valid !== 1'b1 && n < 100) begin
            step();
            n++;
            total++;
            if ({audio_out, trem_out, up_valid, led_out} !== {audio_m, trem_m, valid_m, led_m}) begin
                bad++;
                $display("FAIL up_qual cyc=%0d got=%b want=%b", cyc, {audio_out, trem_out, up_valid, led_out}, {audio_m, trem_m, valid_m, led_m});
            end
        end
        total++;
        if (up_valid !== 1'b1 || tone_tog - tog0 != 2) begin
            bad++;
            $display("FAIL up_valid_rise valid=%b edges=%0d want valid=1 edges=2", up_valid, tone_tog - tog0);
        end
        run_intervals("up", 160, 4, 1'b1);
        tone_hp = 0;
        for (int i = 0; i < HMAX + 20; i++) begin
            step();
            total++;
            if ({audio_out, trem_out, up_valid, led_out} !== {audio_m, trem_m, valid_m, led_m}) begin
                bad++;
                $display("FAIL up_stop cyc=%0d got=%b want=%b", cyc, {audio_out, trem_out, up_valid, led_out}, {audio_m, trem_m, valid_m, led_m});
            end
        end
        total++;
        if (up_valid !== 1'b0 || audio_out !== tone_in) begin
            bad++;
            $display("FAIL up_stopped valid=%b audio=%b want valid=0 audio=%b", up_valid, audio_out, tone_in);
        end
    endtask

    task automatic test_tremolo();
        int zeros;
        octave_sel = 2'b00; tone_hp = 0; tone_in = 1'b1; tremolo_ena = 1'b1; trem_rate = 4'd3;
        for (int i = 0; i < 6; i++) step();
        zeros = 0;
        for (int i = 0; i < 128; i++) begin
            step();
            total++;
            if ({audio_out, trem_out, up_valid, led_out} !== {audio_m, trem_m, valid_m, led_m}) begin
                bad++;
                $display("FAIL trem3 cyc=%0d got=%b want=%b", cyc, {audio_out, trem_out, up_valid, led_out}, {audio_m, trem_m, valid_m, led_m});
            end
            if (trem_out === 1'b0) zeros++;
        end
        total++;
        if (zeros != 64) begin
            bad++;
            $display("FAIL trem3_duty zeros=%0d want=64", zeros);
        end
        trem_rate = 4'd15;
        step(); step();
        zeros = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            total++;
            if ({audio_out, trem_out, up_valid, led_out} !== {audio_m, trem_m, valid_m, led_m}) begin
                bad++;
                $display("FAIL trem15 cyc=%0d got=%b want=%b", cyc, {audio_out, trem_out, up_valid, led_out}, {audio_m, trem_m, valid_m, led_m});
            end
            if (trem_out === 1'b0) zeros++;
        end
        total++;
        if (zeros != 32) begin
            bad++;
            $display("FAIL trem15_duty zeros=%0d want=32", zeros);
        end
        tremolo_ena = 1'b0;
        step();
        for (int i = 0; i < 16; i++) begin
            step();
            total++;
            if (trem_out !== audio_out) begin
                bad++;
                $display("FAIL trem_off cyc=%0d got=%b want=%b", cyc, trem_out, audio_out);
            end
        end
    endtask

    task automatic test_led();
        logic [LN-1:0] start, prev;
        int changes, n;
        trem_rate = 4'd3; led_ena = 1'b1;
        step(); step();
        start = led_out; prev = led_out;
        changes = 0; n = 0;
        while (changes < 12 && n < 450) begin
            step();
            n++;
            total++;
            if ({audio_out, trem_out, up_valid, led_out} !== {audio_m, trem_m, valid_m, led_m}) begin
                bad++;
                $display("FAIL led cyc=%0d got=%b want=%b", cyc, {audio_out, trem_out, up_valid, led_out}, {audio_m, trem_m, valid_m, led_m});
            end
            if (led_out !== prev) begin
                total++;
                if (led_out !== {prev[LN-2:0], ~prev[LN-1]}) begin
                    bad++;
                    $display("FAIL led_step cyc=%0d got=%b want=%b", cyc, led_out, {prev[LN-2:0], ~prev[LN-1]});
                end
                changes++;
                prev = led_out;
            end
        end
        total++;
        if (changes != 12 || led_out !== start) begin
            bad++;
            $display("FAIL led_wrap changes=%0d got=%b want 12 changes back to %b", changes, led_out, start);
        end
        led_ena = 1'b0;
        step();
        for (int i = 0; i < 40; i++) begin
            step();
            total++;
            if (led_out !== '0) begin
                bad++;
                $display("FAIL led_off cyc=%0d got=%b want=0", cyc, led_out);
            end
        end
        led_ena = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (led_out !== led_m) begin
                bad++;
                $display("FAIL led_reenable cyc=%0d got=%b want=%b", cyc, led_out, led_m);
            end
        end
    endtask

    task automatic test_ena();
        octave_sel = 2'b11; tone_hp = 8; tone_ph = 0; led_ena = 1'b1;
        for (int i = 0; i < 60; i++) step();
        ena = 1'b0;
        step();
        total++;
        if ({audio_out, trem_out, led_out} !== '0) begin
            bad++;
            $display("FAIL ena_off got=%b want=0", {audio_out, trem_out, led_out});
        end
        for (int i = 0; i < 30; i++) begin
            step();
            total++;
            if ({audio_out, trem_out, up_valid, led_out} !== {audio_m, trem_m, valid_m, led_m}) begin
                bad++;
                $display("FAIL ena_hold cyc=%0d got=%b want=%b", cyc, {audio_out, trem_out, up_valid, led_out}, {audio_m, trem_m, valid_m, led_m});
            end
        end
        ena = 1'b1;
        step();
        total++;
        if (up_valid !== 1'b0) begin
            bad++;
            $display("FAIL ena_resume_valid got=%b want=0", up_valid);
        end
        for (int i = 0; i < 60; i++) begin
            step();
            total++;
            if ({audio_out, trem_out, up_valid, led_out} !== {audio_m, trem_m, valid_m, led_m}) begin
                bad++;
                $display("FAIL ena_resume cyc=%0d got=%b want=%b", cyc, {audio_out, trem_out, up_valid, led_out}, {audio_m, trem_m, valid_m, led_m});
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) octave_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) tremolo_ena = ~tremolo_ena;
            if ($urandom_range(0, 59) == 0) trem_rate = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 79) == 0) led_ena = ~led_ena;
            if ($urandom_range(0, 99) == 0) tone_hp = $urandom_range(0, 20);
            ena = ($urandom_range(0, 49) != 0);
            step();
            total++;
            if ({audio_out, trem_out, up_valid, led_out} !== {audio_m, trem_m, valid_m, led_m}) begin
                bad++;
                $display("FAIL random cyc=%0d got=%b want=%b", cyc, {audio_out, trem_out, up_valid, led_out}, {audio_m, trem_m, valid_m, led_m});
            end
        end
        ena = 1'b1;
    endtask

    task automatic test_async_reset();
        octave_sel = 2'b00; tone_hp = 3; led_ena = 1'b1; tremolo_ena = 1'b0;
        for (int i = 0; i < 40; i++) step();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({audio_out, trem_out, up_valid, led_out} !== '0) begin
            bad++;
            $display("FAIL async_reset got=%b want=0", {audio_out, trem_out, up_valid, led_out});
        end
        model_reset();
        for (int i = 0; i < 3; i++) step();
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            total++;
            if ({audio_out, trem_out, up_valid, led_out} !== {audio_m, trem_m, valid_m, led_m}) begin
                bad++;
                $display("FAIL after_reset cyc=%0d got=%b want=%b", cyc, {audio_out, trem_out, up_valid, led_out}, {audio_m, trem_m, valid_m, led_m});
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_bypass_latency();
        test_octave_down();
        test_octave_up();
        test_tremolo();
        test_led();
        test_ena();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
